// File: rtl/banked_mem_pkg.sv
// banked_mem_pkg: shared types, read latency (BANKED_MEM_OUT_REG_EN adds a stage) and bank decode
package banked_mem_pkg;
  typedef enum logic {PORT_A, PORT_B} port_e;
`ifdef BANKED_MEM_OUT_REG_EN
  localparam int READ_LATENCY = 2;
`else
  localparam int READ_LATENCY = 1;
`endif
  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int unsigned addr_total, input int unsigned bank_bits);
    return (addr >> (addr_total - bank_bits)) & ((32'd1 << bank_bits) - 32'd1);
  endfunction
endpackage

// File: rtl/banked_sp_arbiter_mem_if.sv
// banked_sp_arbiter_mem_if: two-port request/grant/read-return bus for the banked memory
interface banked_sp_arbiter_mem_if #(parameter int ADDR_TOTAL = 10, parameter int WIDTH = 8);
  logic                  i_req_a, i_we_a, o_gnt_a, o_rvalid_a;
  logic [ADDR_TOTAL-1:0] i_addr_a;
  logic [WIDTH-1:0]      i_din_a, o_dout_a;
  logic                  i_req_b, i_we_b, o_gnt_b, o_rvalid_b;
  logic [ADDR_TOTAL-1:0] i_addr_b;
  logic [WIDTH-1:0]      i_din_b, o_dout_b;
  logic                  o_conflict;
  modport master(
    output i_req_a, i_we_a, i_addr_a, i_din_a, i_req_b, i_we_b, i_addr_b, i_din_b,
    input  o_gnt_a, o_rvalid_a, o_dout_a, o_gnt_b, o_rvalid_b, o_dout_b, o_conflict
  );
  modport slave(
    input  i_req_a, i_we_a, i_addr_a, i_din_a, i_req_b, i_we_b, i_addr_b, i_din_b,
    output o_gnt_a, o_rvalid_a, o_dout_a, o_gnt_b, o_rvalid_b, o_dout_b, o_conflict
  );
endinterface

// File: rtl/banked_sp_bank.sv
// banked_sp_bank: single-port synchronous RAM, read data registered, contents not reset
module banked_sp_bank #(
  parameter int AW    = 8,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);
  logic [WIDTH-1:0] mem [2**AW];
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) mem[i_addr] <= i_din;
      else o_dout <= mem[i_addr];
    end
  end
endmodule

// File: rtl/banked_sp_arbiter_mem.sv
// banked_sp_arbiter_mem: two-port banked memory with round-robin bank arbitration; BANKED_MEM_OUT_REG_EN adds an output stage
module banked_sp_arbiter_mem
  import banked_mem_pkg::*;
#(
  parameter int ADDR_TOTAL = 10,
  parameter int WIDTH      = 8,
  parameter int NUM_BANK   = 4,
  parameter int BANK_BITS  = $clog2(NUM_BANK)
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  banked_sp_arbiter_mem_if.slave  bus
);
  localparam int LOCAL_BITS = ADDR_TOTAL - BANK_BITS;
  logic [BANK_BITS-1:0]  bank_a, bank_b, rbank_a, rbank_b;
  logic [LOCAL_BITS-1:0] local_a, local_b;
  logic                  conflict, gnt_a, gnt_b, rd_a, rd_b;
  logic [WIDTH-1:0]      bank_dout [NUM_BANK];
  logic [WIDTH-1:0]      data_a, data_b, hold_a, hold_b;
  port_e                 ptr;
  always_comb begin
    bank_a   = BANK_BITS'(bank_of(32'(bus.i_addr_a), ADDR_TOTAL, BANK_BITS));
    bank_b   = BANK_BITS'(bank_of(32'(bus.i_addr_b), ADDR_TOTAL, BANK_BITS));
    local_a  = bus.i_addr_a[LOCAL_BITS-1:0];
    local_b  = bus.i_addr_b[LOCAL_BITS-1:0];
    conflict = bus.i_req_a && bus.i_req_b && bank_a == bank_b;
    gnt_a    = i_rst_n && bus.i_req_a && (!conflict || ptr == PORT_A);
    gnt_b    = i_rst_n && bus.i_req_b && (!conflict || ptr == PORT_B);
    data_a   = rd_a ? bank_dout[rbank_a] : hold_a;
    data_b   = rd_b ? bank_dout[rbank_b] : hold_b;
  end
  assign bus.o_conflict = conflict;
  assign bus.o_gnt_a    = gnt_a;
  assign bus.o_gnt_b    = gnt_b;
  // priority passes to the loser, so a persistent loser wins next cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr    <= PORT_A;
      rd_a   <= 1'b0;
      rd_b   <= 1'b0;
      hold_a <= '0;
      hold_b <= '0;
    end else begin
      if (conflict) ptr <= ptr == PORT_A ? PORT_B : PORT_A;
      rd_a   <= gnt_a && !bus.i_we_a;
      rd_b   <= gnt_b && !bus.i_we_b;
      hold_a <= data_a;
      hold_b <= data_b;
    end
  end
  always_ff @(posedge i_clk) begin
    rbank_a <= bank_a;
    rbank_b <= bank_b;
  end
  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic hit_a, hit_b;
    assign hit_a = gnt_a && bank_a == BANK_BITS'(b);
    assign hit_b = gnt_b && bank_b == BANK_BITS'(b);
    banked_sp_bank #(.AW(LOCAL_BITS), .WIDTH(WIDTH)) u_bank (
      .i_clk  (i_clk),
      .i_en   (hit_a || hit_b),
      .i_we   (hit_a ? bus.i_we_a : bus.i_we_b),
      .i_addr (hit_a ? local_a : local_b),
      .i_din  (hit_a ? bus.i_din_a : bus.i_din_b),
      .o_dout (bank_dout[b])
    );
  end
`ifdef BANKED_MEM_OUT_REG_EN
  logic             rv_a_q, rv_b_q;
  logic [WIDTH-1:0] do_a_q, do_b_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rv_a_q <= 1'b0;
      rv_b_q <= 1'b0;
      do_a_q <= '0;
      do_b_q <= '0;
    end else begin
      rv_a_q <= rd_a;
      rv_b_q <= rd_b;
      do_a_q <= data_a;
      do_b_q <= data_b;
    end
  end
  assign bus.o_rvalid_a = rv_a_q;
  assign bus.o_rvalid_b = rv_b_q;
  assign bus.o_dout_a   = do_a_q;
  assign bus.o_dout_b   = do_b_q;
`else
  assign bus.o_rvalid_a = rd_a;
  assign bus.o_rvalid_b = rd_b;
  assign bus.o_dout_a   = data_a;
  assign bus.o_dout_b   = data_b;
`endif
endmodule
